// File: rtl/cadder_issue_ctrl.sv
// ============================================================================
// cadder_issue_ctrl: issue/capture controller for the multi-cycle cadder stage
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module cadder_issue_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_err,
  output logic [DATA_WIDTH-1:0] cad_a,
  output logic [DATA_WIDTH-1:0] cad_b,
  output logic                  cad_add_en,
  output logic                  cad_enable,
  input  logic                  cad_ready,
  input  logic [DATA_WIDTH-1:0] cad_result,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  done_count
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] c_WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [WD_W-1:0]       r_wd;
  logic [DATA_WIDTH-1:0] r_cad_a;
  logic [DATA_WIDTH-1:0] r_cad_b;
  logic                  r_cad_add_en;
  logic                  r_cad_enable;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_result;
  logic                  r_out_err;
  logic [CNT_WIDTH-1:0]  r_done_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wd         <= '0;
      r_cad_a      <= '0;
      r_cad_b      <= '0;
      r_cad_add_en <= 1'b0;
      r_cad_enable <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_err    <= 1'b0;
      r_done_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cad_enable <= 1'b0;
          if (in_valid) begin
            r_cad_a      <= in_a;
            r_cad_b      <= in_b;
            r_cad_add_en <= in_op;
            r_cad_enable <= 1'b1;
            r_wd         <= '0;
            r_state      <= S_RUN;
          end
        end
        S_RUN: begin
          r_wd <= r_wd + WD_W'(1);
          // A ready pulse on the final watchdog edge still wins over the timeout.
          if (cad_ready) begin
            r_out_result <= cad_result;
            r_out_err    <= 1'b0;
            r_out_valid  <= 1'b1;
            r_cad_enable <= 1'b0;
            r_done_count <= r_done_count + CNT_WIDTH'(1);
            r_state      <= S_DONE;
          end else if (r_wd == c_WD_LAST) begin
            r_out_result <= '0;
            r_out_err    <= 1'b1;
            r_out_valid  <= 1'b1;
            r_cad_enable <= 1'b0;
            r_done_count <= r_done_count + CNT_WIDTH'(1);
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          r_cad_enable <= 1'b0;
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_cad_enable <= 1'b0;
          r_out_valid  <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign cad_a      = r_cad_a;
  assign cad_b      = r_cad_b;
  assign cad_add_en = r_cad_add_en;
  assign cad_enable = r_cad_enable;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_err    = r_out_err;
  assign done_count = r_done_count;

endmodule

`default_nettype wire

// File: tb/tb_cadder_issue_ctrl.sv
// ============================================================================
// tb_cadder_issue_ctrl: scoreboard bench with a behavioural cadder model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cadder_issue_ctrl;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_op;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          out_err;
  logic [DW-1:0] cad_a;
  logic [DW-1:0] cad_b;
  logic          cad_add_en;
  logic          cad_enable;
  logic          cad_ready;
  logic [DW-1:0] cad_result;
  logic          busy;
  logic [CW-1:0] done_count;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  bit stub = 0;
  logic [DW:0] exp_q[$];
  time acc_times[$];

  cadder_issue_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(8), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err),
    .cad_a(cad_a), .cad_b(cad_b), .cad_add_en(cad_add_en),
    .cad_enable(cad_enable), .cad_ready(cad_ready), .cad_result(cad_result),
    .busy(busy), .done_count(done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural cadder: ready pulses on the fourth enabled edge; enable low restarts it.
  int          m_cnt = 0;
  logic        m_rdy = 1'b0;
  logic [DW-1:0] m_res = '0;
  always @(posedge clk) begin
    if (!cad_enable) begin
      m_cnt <= 0;
      m_rdy <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 1;
      m_rdy <= (m_cnt == 2);
      m_res <= cad_add_en ? DW'(cad_a + cad_b) : DW'(cad_a - cad_b);
    end
  end
  assign cad_ready  = m_rdy & ~stub;
  assign cad_result = m_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: each accepted operation yields exactly one result, in order.
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      logic [DW-1:0] r;
      r = in_op ? DW'(in_a + in_b) : DW'(in_a - in_b);
      exp_q.push_back(stub ? {1'b1, {DW{1'b0}}} : {1'b0, r});
      acc_times.push_back($time);
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        check("sb_result", out_result, e[DW-1:0]);
        check("sb_err", out_err, e[DW]);
      end
    end
  end

  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic op);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("issue_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_done++;
  endtask

  task automatic drain(input bit rnd);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) done = 1;
      n++;
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] a0, b0;
    int base;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_cad_enable", cad_enable, 0);
    check("rst_done_count", done_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_result", out_result, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Nominal op with latency and enable window checks.
    issue(8'h35, 8'h12, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("lat_enable_high", cad_enable, 1);
      check("lat_no_valid", out_valid, 0);
    end
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    check("lat_result", out_result, 8'h47);
    check("lat_err", out_err, 0);
    check("lat_enable_low", cad_enable, 0);
    check("lat_done_count", done_count, 1);

    // Backpressure in DONE, with an ignored input pulse.
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55; in_op = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_result", out_result, 8'h47);
      check("bp_err", out_err, 0);
      check("bp_in_ready", in_ready, 0);
      check("bp_enable", cad_enable, 0);
      @(posedge clk); #1 in_valid = 1'b0;
    end
    drain(0);
    @(negedge clk);
    check("hs_in_ready", in_ready, 1);
    check("hs_valid_clr", out_valid, 0);
    check("hs_result_kept", out_result, 8'h47);

    // Watchdog timeout.
    stub = 1;
    issue(8'h21, 8'h43, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("to_no_valid", out_valid, 0);
    end
    @(negedge clk);
    check("to_valid", out_valid, 1);
    check("to_err", out_err, 1);
    check("to_result", out_result, 0);
    check("to_done_count", done_count, 2);
    drain(0);
    stub = 0;
    @(negedge clk);
    check("to_err_clr", out_err, 0);

    // Asynchronous reset mid-operation.
    issue(8'h10, 8'h20, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_enable", cad_enable, 0);
    check("arst_cad_a", cad_a, 0);
    check("arst_done_count", done_count, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    exp_q.delete();
    exp_done = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    issue(8'hFF, 8'h01, 1'b1);
    drain(0);
    check("arst_after_count", done_count, 1);

    // Back-to-back throughput.
    base = acc_times.size();
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n;
      in_a = DW'($urandom); in_b = DW'($urandom); in_op = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 30) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk); #1;
      exp_done++;
    end
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    out_ready = 1'b0;
    if (acc_times.size() >= base + 3) begin
      check("b2b_gap1", 32'(acc_times[base+1] - acc_times[base]), 60);
      check("b2b_gap2", 32'(acc_times[base+2] - acc_times[base+1]), 60);
    end else begin
      check("b2b_accepts", acc_times.size() - base, 3);
    end
    check("b2b_done_count", done_count, exp_done);

    // Operands held during RUN while inputs churn.
    a0 = DW'($urandom); b0 = DW'($urandom);
    issue(a0, b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      in_a = DW'($urandom); in_b = DW'($urandom);
      @(negedge clk);
      check("hold_cad_a", cad_a, a0);
      check("hold_cad_b", cad_b, b0);
      @(posedge clk); #1;
    end
    drain(0);

    // Randomised traffic with occasional stalled adder and random backpressure.
    for (int i = 0; i < 20; i++) begin
      stub = ($urandom_range(0, 5) == 0);
      issue(DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));
      drain(1);
      stub = 0;
    end

    repeat (2) @(negedge clk);
    check("final_done_count", done_count, exp_done);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cadder_issue_ctrl.md
Name: cadder_issue_ctrl

Overview:
- Upstream issue controller for the multi-cycle half-width `cadder` stage.
- Accepts operand pairs over a valid/ready handshake and registers them. Holds them stable on the adder inputs and drives its level-sensitive `enable` until its one-cycle `ready` pulse.
- Captures the result and presents it downstream with valid/ready backpressure.
- Adds a watchdog timeout and a completed-operation counter.

Parameters:
- DATA_WIDTH, 8, operand/result width; must be even (matches adder).
- TIMEOUT, 8, max cycles in RUN waiting for cad_ready before error; must be ≥4.
- CNT_WIDTH, 16, width of done_count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream operation valid
- in_ready  output  1  controller can accept (IDLE only)
- in_a  input  DATA_WIDTH  operand A
- in_b  input  DATA_WIDTH  operand B
- in_op  input  1  forwarded to cad_add_en (1 = add)
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_result  output  DATA_WIDTH  captured result
- out_err  output  1  result invalid due to timeout (qualified by out_valid)
- cad_a  output  DATA_WIDTH  to adder A
- cad_b  output  DATA_WIDTH  to adder B
- cad_add_en  output  1  to adder add_en
- cad_enable  output  1  to adder enable
- cad_ready  input  1  from adder ready
- cad_result  input  DATA_WIDTH  from adder result
- busy  output  1  state != IDLE
- done_count  output  CNT_WIDTH  completed operations (incl. errored), wraps

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all registered outputs 0 (cad_a, cad_b, cad_add_en, cad_enable, out_valid, out_result, out_err, done_count, watchdog). Reset mid-operation aborts it; no output is produced.
- All outputs registered except in_ready = (state==IDLE) and busy.
- States: IDLE, RUN, DONE.
- IDLE:
  - cad_enable=0.
  - On in_valid & in_ready at edge T: load in_a/in_b/in_op into cad_a/cad_b/cad_add_en; cad_enable←1; watchdog←0; →RUN.
- RUN:
  - cad_a/cad_b/cad_add_en held constant; in_* ignored.
  - Watchdog increments each edge.
  - Sampled cad_ready=1: out_result←cad_result; out_err←0; out_valid←1; cad_enable←0; done_count+1; →DONE.
  - Else if watchdog==TIMEOUT-1: out_result←0; out_err←1; out_valid←1; cad_enable←0; done_count+1; →DONE.
  - cad_ready has priority over timeout on the same edge.
- With a conforming adder: ready sampled high at edge T+4, so out_valid is high from T+4. Latency is 4 cycles from accept edge to out_valid.
- DONE:
  - out_valid=1; out_result/out_err stable until out_valid & out_ready.
  - On that handshake edge: out_valid←0, out_err←0, →IDLE.
  - out_result retains its value after the handshake.
- cad_enable is 0 in DONE and IDLE. This guarantees ≥1 low-enable edge between operations, so the adder counter re-synchronises to 0 before the next op.
- Throughput: min 6 cycles per op (accept T; DONE T+4; handshake T+5; next accept T+6).
- cad_ready seen in IDLE or DONE is ignored.
- done_count wraps from 2^CNT_WIDTH-1 to 0.

Test Plan:
- Reset, then accept A=0x35, B=0x12, op=1 with behavioural cadder → cad_enable high from T to T+4; out_valid at T+4; out_result equals model output; out_err=0; done_count=1.
- out_ready held 0 for 5 cycles in DONE → out_valid, out_result, out_err stable; in_ready=0; cad_enable=0; a pulse on in_valid is not accepted; handshake then → IDLE next edge.
- cad_ready stubbed 0 → out_valid after exactly TIMEOUT=8 RUN edges with out_err=1, out_result=0; done_count increments.
- Assert rst_n=0 asynchronously mid-RUN (between clocks) → all outputs 0 immediately; state IDLE; following op A=0xFF, B=0x01 completes normally.
- Three back-to-back ops, in_valid and out_ready tied 1 → accepts exactly 6 cycles apart; three correct results in order; done_count=3; cad_enable low ≥1 edge between ops.
- Change in_a/in_b every cycle during RUN → cad_a/cad_b remain the values captured at accept.
